// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it as 32-bit words into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          writeINS,
    output logic [AW-1:0] WriteAddress,
    output logic [31:0]   writeDataINS,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;
`endif
    state_t      r_state, w_next;
    logic [15:0] r_n, r_cnt;
    logic [23:0] r_asm;
    logic [1:0]  r_idx;
    logic        w_acc, w_start, w_last;
    logic [15:0] w_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    assign rx_ready = r_state inside {HDR_HI, HDR_LO, DATA, CHK};
`else
    assign rx_ready = r_state inside {HDR_HI, HDR_LO, DATA};
`endif
    assign cpu_hold   = !(r_state inside {IDLE, DONE});
    assign load_done  = r_state == DONE;
    assign load_error = r_state == ERR;
    assign w_acc      = rx_valid && rx_ready;
    assign w_start    = load_start && (r_state inside {IDLE, DONE, ERR});
    assign w_n        = {r_n[15:8], rx_data};
    assign w_last     = r_idx == 2'd3 && r_cnt == r_n - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = HDR_HI;
        else if (w_acc)
            case (r_state)
                HDR_HI: w_next = HDR_LO;
                HDR_LO: w_next = (w_n == 16'd0 || w_n > 16'(DEPTH)) ? ERR : DATA;
                DATA: if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = CHK;
`else
                    w_next = DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: w_next = (rx_data == r_sum) ? DONE : ERR;
`endif
                default: ;
            endcase
    end

    // The final word's write strobe lands in the same cycle the FSM enters DONE/CHK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeINS     <= 1'b0;
            WriteAddress <= '0;
            writeDataINS <= '0;
            r_n          <= '0;
            r_cnt        <= '0;
            r_asm        <= '0;
            r_idx        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            writeINS <= 1'b0;
            if (w_start) begin
                r_cnt <= '0;
                r_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum <= '0;
`endif
            end
            if (w_acc && r_state == HDR_HI) r_n <= {rx_data, 8'h00};
            if (w_acc && r_state == HDR_LO) r_n <= w_n;
            if (w_acc && r_state == DATA) begin
                r_asm <= {r_asm[15:0], rx_data};
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    writeINS     <= 1'b1;
                    writeDataINS <= {r_asm, rx_data};
                    WriteAddress <= AW'(r_cnt);
                    r_cnt        <= r_cnt + 16'd1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_acc && r_state != CHK) r_sum <= r_sum ^ rx_data;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default DEPTH=128, AW=30).
module tb_imem_loader;
    logic        clk = 1'b0, rst = 1'b0, load_start = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, writeINS, cpu_hold, load_done, load_error;
    logic [29:0] WriteAddress;
    logic [31:0] writeDataINS;
    int          n_chk = 0, n_fail = 0, base;
    logic [7:0]  tb_sum;
    logic [29:0] qa[$];
    logic [31:0] qd[$];
    logic [7:0]  s [10] = '{8'h00, 8'h02, 8'h8C, 8'h08, 8'h00, 8'h00, 8'h21, 8'h09, 8'h00, 8'h05};

    imem_loader #(.DEPTH(128), .AW(30)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .writeINS(writeINS), .WriteAddress(WriteAddress),
        .writeDataINS(writeDataINS), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (writeINS) begin
        qa.push_back(WriteAddress);
        qd.push_back(writeDataINS);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input int idx, input logic [29:0] a, input logic [31:0] d);
        if (idx < qa.size()) begin
            check("wr_addr", {2'b00, qa[idx]}, {2'b00, a});
            check("wr_data", qd[idx], d);
        end else check("wr_missing", qa.size(), idx + 1);
    endtask

    task automatic start_load();
        tb_sum = 8'h00;
        rx_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data = 8'h5A;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data = b;
        tb_sum ^= b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send(w[8*k +: 8], gap);
    endtask

    task automatic send_sum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(tb_sum, 0);
`endif
    endtask

    task automatic end_rx();
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i), 8'(~i), 8'h5A, 8'(i * 3)};
    endfunction

    task automatic check_reset_outputs();
        check("rst_ready", rx_ready, 0);
        check("rst_wr", writeINS, 0);
        check("rst_addr", {2'b00, WriteAddress}, 0);
        check("rst_data", writeDataINS, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        #3 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // gap-free two-word load
        start_load();
        check("hold_hdr", cpu_hold, 1);
        check("ready_hdr", rx_ready, 1);
        for (int k = 0; k < 10; k++) send(s[k], 0);
        send_sum();
        end_rx();
        check("n_wr", qa.size(), 2);
        check_wr(0, 30'd0, 32'h8C080000);
        check_wr(1, 30'd1, 32'h21090005);
        check("done", load_done, 1);
        check("hold_done", cpu_hold, 0);
        check("err_done", load_error, 0);
        check("ready_done", rx_ready, 0);
        check("wr_idle", writeINS, 0);
        check("addr_hold", {2'b00, WriteAddress}, 1);
        check("data_hold", writeDataINS, 32'h21090005);

        // bytes while not ready are ignored
        base = qa.size();
        rx_valid = 1'b1;
        rx_data = 8'hFF;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check("ignored_wr", qa.size(), base);
        check("ignored_done", load_done, 1);

        // zero word count
        start_load();
        check("done_clr", load_done, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        end_rx();
        check("err_zero", load_error, 1);
        check("hold_err", cpu_hold, 1);
        check("ready_err", rx_ready, 0);
        check("n_wr_zero", qa.size(), base);

        // restart after error
        start_load();
        check("err_clr", load_error, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send_word(32'hDEADBEEF, 0);
        send_sum();
        end_rx();
        check("done_restart", load_done, 1);
        check("n_wr_restart", qa.size(), base + 1);
        check_wr(base, 30'd0, 32'hDEADBEEF);

        // word count above DEPTH
        base = qa.size();
        start_load();
        send(8'h00, 0);
        send(8'h81, 0);
        end_rx();
        check("err_big", load_error, 1);
        check("n_wr_big", qa.size(), base);

        // exactly DEPTH words
        start_load();
        send(8'h00, 0);
        send(8'h80, 0);
        for (int i = 0; i < 128; i++) send_word(pat(i), 0);
        send_sum();
        end_rx();
        check("done_full", load_done, 1);
        check("n_wr_full", qa.size(), base + 128);
        begin
            int bad = 0;
            for (int i = 0; i < 128; i++)
                if (base + i >= qa.size() || qa[base + i] != 30'(i) || qd[base + i] != pat(i)) bad++;
            check("full_content", bad, 0);
        end

        // random gaps and an ignored mid-load start
        base = qa.size();
        start_load();
        for (int k = 0; k < 10; k++) begin
            send(s[k], int'($urandom_range(0, 2)));
            if (k == 4) begin
                rx_valid = 1'b0;
                load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
                check("mid_hold", cpu_hold, 1);
                check("mid_err", load_error, 0);
                check("mid_ready", rx_ready, 1);
            end
        end
        send_sum();
        end_rx();
        check("done_gaps", load_done, 1);
        check("n_wr_gaps", qa.size(), base + 2);
        check_wr(base, 30'd0, 32'h8C080000);
        check_wr(base + 1, 30'd1, 32'h21090005);

        // reset after two of three words
        base = qa.size();
        start_load();
        send(8'h00, 0);
        send(8'h03, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        send(8'hCC, 0);
        send(8'hDD, 0);
        send_word(32'h33333333, 0);
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("n_wr_rst", qa.size(), base + 2);
        check_wr(base, 30'd0, 32'h11111111);
        check_wr(base + 1, 30'd1, 32'h22222222);
        check("rst_idle_hold", cpu_hold, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        base = qa.size();
        start_load();
        send(8'h00, 0);
        send(8'h01, 0);
        send_word(32'h3C0B1000, 0);
        send(8'h26, 0);
        end_rx();
        check("chk_good", load_done, 1);
        start_load();
        send(8'h00, 0);
        send(8'h01, 0);
        send_word(32'h3C0B1000, 0);
        send(8'h27, 0);
        end_rx();
        check("chk_bad", load_error, 1);
        check("n_wr_chk", qa.size(), base + 2);
        check_wr(base + 1, 30'd0, 32'h3C0B1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 128: instruction-memory capacity in 32-bit words, max legal word count.
REQ-002 Parameter AW, default 30: width of WriteAddress, the word address bits [31:2].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  request a new program load; one-cycle pulse.
REQ-006 rx_valid  input  1  byte on rx_data is valid.
REQ-007 rx_data  input  8  program byte stream.
REQ-008 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high at a rising edge.
REQ-009 writeINS  output  1  instruction-memory write strobe.
REQ-010 WriteAddress  output  AW  instruction-memory word address.
REQ-011 writeDataINS  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU PC/fetch while a load is in progress.
REQ-013 load_done  output  1  last load completed successfully; level.
REQ-014 load_error  output  1  last load aborted; level.

Function
REQ-015 States SHALL be IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR.
REQ-016 load_start in IDLE, DONE or ERR -> HDR_HI next cycle, clearing load_done, load_error, word counter and byte index, and asserting cpu_hold; load_start is ignored in every other state.
REQ-017 Stream format: 16-bit word count N big-endian (HDR_HI, then HDR_LO), then N words of 4 bytes each, MSB first.
REQ-018 rx_ready SHALL be 1 only in HDR_HI, HDR_LO, DATA and CHK, and 0 in every other state.
REQ-019 In HDR_LO, on byte accept: N==0 or N>DEPTH -> ERR; otherwise -> DATA.
REQ-020 In DATA, bytes shift into a 32-bit assembly register MSB-first; a 2-bit byte index wraps 3->0.
REQ-021 On the 4th byte accept, the cycle after, writeINS SHALL be 1 for exactly one cycle, with writeDataINS = the assembled word and WriteAddress = word counter (0..N-1); the counter then increments.
REQ-022 Back-to-back bytes every cycle SHALL be sustained with no dropped byte and no stall.
REQ-023 After word N-1 is written: -> CHK if IMEM_LOADER_CHECKSUM_EN is defined, else -> DONE.
REQ-024 DONE: cpu_hold=0, load_done=1. ERR: cpu_hold=1, load_error=1. Both states are held until load_start or rst.
REQ-025 Outside write cycles, writeINS=0 and WriteAddress/writeDataINS hold their last values.
REQ-026 A write strobe and a state transition in the same cycle SHALL both take effect; the final word write is never lost on entry to DONE or CHK.
REQ-027 Bytes presented while rx_ready=0 SHALL be ignored and have no effect.

Reset
REQ-028 rst SHALL force: state=IDLE, rx_ready=0, writeINS=0, WriteAddress=0, writeDataINS=0, cpu_hold=0, load_done=0, load_error=0, and all counters and the checksum to 0.
REQ-029 rst mid-load SHALL abort immediately with no further writes; words already written are not rolled back.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: a running XOR of all header and data bytes is kept; CHK accepts one byte; byte equal to the XOR -> DONE, otherwise -> ERR.
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN undefined: no CHK state, no checksum logic, and no trailing byte is consumed.

Verification
REQ-032 Bytes 00 02 | 8C 08 00 00 | 21 09 00 05, sent on consecutive cycles -> writeINS pulses at addr 0 data 8C080000 and addr 1 data 21090005; load_done=1; cpu_hold falls.
REQ-033 Header 00 00 -> ERR, load_error=1, cpu_hold=1, no writeINS; a following load_start restarts the load cleanly.
REQ-034 Header 00 81 with DEPTH=128 -> ERR after the 2nd byte; no write occurs.
REQ-035 CHECKSUM_EN, stream 00 01 | 3C 0B 10 00 with check byte 26 (XOR of all six bytes) -> DONE; same stream with check byte 27 -> ERR, although the word is still written at addr 0.
REQ-036 rst asserted after 2 of 3 words -> all outputs reach reset values without waiting for a clock edge; no 3rd write; memory keeps words 0 and 1.
REQ-037 rx_valid toggled randomly, and load_start pulsed mid-load -> write data and addresses identical to the gap-free run; the mid-load load_start is ignored.
